// File: rtl/pfl_cfg_pkg.sv
// Shared types for the PFL configuration sequencer: LED-visible state codes,
// the default page-select width and the retry counter width.
package pfl_cfg_pkg;

  localparam int PAGE_W_DEF = 3;
  localparam int RETRY_W    = 2;

  // Encodings are fixed because state_o drives board LEDs directly.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_BOOT_WAIT = 4'd1,
    ST_READ_SEL  = 4'd2,
    ST_APPLY     = 4'd3,
    ST_NRECONF   = 4'd4,
    ST_NRESET    = 4'd5,
    ST_WAIT_DONE = 4'd6
  } state_t;

endpackage

// File: rtl/pfl_cfg_sequencer_sync.sv
// 1-bit two-flop synchroniser with asynchronous active-high clear.
// Output follows the input after two clock edges.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pfl_cfg_sequencer.sv
// Boot/reconfiguration sequencer between CPLD, PFL core and flash controller:
// flash ownership, timed nreconfigure/nreset pulses, conf_done supervision with retry and factory fallback.
module pfl_cfg_sequencer
  import pfl_cfg_pkg::*;
#(
  parameter int NUM_PAGES       = 3,
  parameter int PAGE_W          = PAGE_W_DEF,
  parameter int FACTORY_PAGE    = 0,
  parameter int NRECONF_CYC     = 16,
  parameter int NRESET_CYC      = 16,
  parameter int CFG_TIMEOUT_CYC = 2**24,
  parameter int MAX_RETRY       = 1,
  parameter int TMR_W           = 25
) (
  input  logic               clkin_max_100,
  input  logic               sys_reset,
  input  logic               fpga_conf_done,
  input  logic               fl_done,
  input  logic [PAGE_W-1:0]  fl_page,
  input  logic               cfg_req,
  input  logic [PAGE_W-1:0]  cfg_page,
  input  logic               cfg_next,
  output logic               pfl_grant,
  output logic               fl_req,
  output logic [PAGE_W-1:0]  fpga_pgm,
  output logic               pfl_nreconfigure,
  output logic               pfl_nreset,
  output logic [PAGE_W-1:0]  active_page,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               busy,
  output logic               cfg_ok,
  output logic               cfg_err,
  output logic [3:0]         state_o
);

  localparam logic [TMR_W-1:0]   NRECONF_LAST = TMR_W'(NRECONF_CYC - 1);
  localparam logic [TMR_W-1:0]   NRESET_LAST  = TMR_W'(NRESET_CYC - 1);
  localparam logic [TMR_W-1:0]   CFG_LAST     = TMR_W'(CFG_TIMEOUT_CYC - 1);
  localparam logic [PAGE_W-1:0]  FACTORY_PG   = PAGE_W'(FACTORY_PAGE);
  localparam logic [PAGE_W:0]    NUM_PG       = (PAGE_W+1)'(NUM_PAGES);
  localparam logic [RETRY_W-1:0] RETRY_LIM    = RETRY_W'(MAX_RETRY);

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [PAGE_W-1:0] target;
  logic              armed;
  logic              conf_done_s;

  logic tmr_reconf_end;
  logic tmr_reset_end;
  logic tmr_cfg_end;

  // Out-of-range page numbers never reach the PFL; they fall back to factory.
  function automatic logic [PAGE_W-1:0] clamp_page(input logic [PAGE_W-1:0] p);
    return ({1'b0, p} < NUM_PG) ? p : FACTORY_PG;
  endfunction

  function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0] p);
    logic [PAGE_W:0] n;
    n = {1'b0, p} + (PAGE_W+1)'(1);
    return (n >= NUM_PG) ? '0 : n[PAGE_W-1:0];
  endfunction

  sync_2ff u_conf_done_sync (
    .clk (clkin_max_100),
    .clr (sys_reset),
    .d   (fpga_conf_done),
    .q   (conf_done_s)
  );

  assign tmr_reconf_end = (timer == NRECONF_LAST);
  assign tmr_reset_end  = (timer == NRESET_LAST);
  assign tmr_cfg_end    = (timer == CFG_LAST);
  assign state_o        = state;

  always_ff @(posedge clkin_max_100 or posedge sys_reset) begin
    if (sys_reset) begin
      state            <= ST_BOOT_WAIT;
      timer            <= '0;
      target           <= FACTORY_PG;
      armed            <= 1'b0;
      pfl_grant        <= 1'b1;
      fl_req           <= 1'b0;
      fpga_pgm         <= FACTORY_PG;
      pfl_nreconfigure <= 1'b1;
      pfl_nreset       <= 1'b1;
      active_page      <= FACTORY_PG;
      retry_cnt        <= '0;
      busy             <= 1'b1;
      cfg_ok           <= 1'b0;
      cfg_err          <= 1'b0;
    end else begin
      timer <= timer + TMR_W'(1);
      case (state)
        ST_BOOT_WAIT: begin
          if (conf_done_s) begin
            state     <= ST_READ_SEL;
            timer     <= '0;
            pfl_grant <= 1'b0;
            fl_req    <= 1'b1;
          end else if (tmr_cfg_end) begin
            state   <= ST_IDLE;
            timer   <= '0;
            cfg_err <= 1'b1;
            busy    <= 1'b0;
          end
        end

        ST_READ_SEL: begin
          if (fl_done || tmr_cfg_end) begin
            target    <= fl_done ? clamp_page(fl_page) : FACTORY_PG;
            state     <= ST_APPLY;
            timer     <= '0;
            pfl_grant <= 1'b1;
            fl_req    <= 1'b0;
          end
        end

        ST_APPLY: begin
          fpga_pgm         <= target;
          armed            <= 1'b0;
          pfl_grant        <= 1'b1;
          fl_req           <= 1'b0;
          pfl_nreconfigure <= 1'b0;
          state            <= ST_NRECONF;
          timer            <= '0;
        end

        ST_NRECONF: begin
          if (tmr_reconf_end) begin
            pfl_nreconfigure <= 1'b1;
            pfl_nreset       <= 1'b0;
            state            <= ST_NRESET;
            timer            <= '0;
          end
        end

        ST_NRESET: begin
          if (tmr_reset_end) begin
            pfl_nreset <= 1'b1;
            state      <= ST_WAIT_DONE;
            timer      <= '0;
          end
        end

        ST_WAIT_DONE: begin
          // conf_done is still high from the previous image until the FPGA
          // drops it, so only a low-to-high sequence counts as success.
          if (!conf_done_s) begin
            armed <= 1'b1;
          end
          if (armed && conf_done_s) begin
            cfg_ok      <= 1'b1;
            cfg_err     <= 1'b0;
            active_page <= target;
            retry_cnt   <= '0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
            timer       <= '0;
          end else if (tmr_cfg_end) begin
            timer <= '0;
            if (retry_cnt < RETRY_LIM) begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
              state     <= ST_APPLY;
            end else if (target != FACTORY_PG) begin
              target    <= FACTORY_PG;
              retry_cnt <= '0;
              state     <= ST_APPLY;
            end else begin
              cfg_err <= 1'b1;
              cfg_ok  <= 1'b0;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end
          end
        end

        ST_IDLE: begin
          timer <= timer;
          if (cfg_req || cfg_next) begin
            target    <= cfg_req ? clamp_page(cfg_page) : next_page(active_page);
            retry_cnt <= '0;
            cfg_ok    <= 1'b0;
            cfg_err   <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_APPLY;
            timer     <= '0;
          end
        end

        default: begin
          state <= ST_IDLE;
          timer <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pfl_cfg_sequencer.sv
// Directed bench for pfl_cfg_sequencer: boot, stale conf_done, retry/fallback,
// total failure, IDLE request handling and asynchronous reset mid-pulse.
module tb_pfl_cfg_sequencer;

  logic       clk;
  logic       sys_reset;
  logic       fpga_conf_done;
  logic       fl_done;
  logic [2:0] fl_page;
  logic       cfg_req;
  logic [2:0] cfg_page;
  logic       cfg_next;
  logic       pfl_grant;
  logic       fl_req;
  logic [2:0] fpga_pgm;
  logic       pfl_nreconfigure;
  logic       pfl_nreset;
  logic [2:0] active_page;
  logic [1:0] retry_cnt;
  logic       busy;
  logic       cfg_ok;
  logic       cfg_err;
  logic [3:0] state_o;

  int tests = 0;
  int fails = 0;

  pfl_cfg_sequencer #(
    .NUM_PAGES       (3),
    .PAGE_W          (3),
    .FACTORY_PAGE    (0),
    .NRECONF_CYC     (4),
    .NRESET_CYC      (4),
    .CFG_TIMEOUT_CYC (64),
    .MAX_RETRY       (1),
    .TMR_W           (25)
  ) dut (
    .clkin_max_100    (clk),
    .sys_reset        (sys_reset),
    .fpga_conf_done   (fpga_conf_done),
    .fl_done          (fl_done),
    .fl_page          (fl_page),
    .cfg_req          (cfg_req),
    .cfg_page         (cfg_page),
    .cfg_next         (cfg_next),
    .pfl_grant        (pfl_grant),
    .fl_req           (fl_req),
    .fpga_pgm         (fpga_pgm),
    .pfl_nreconfigure (pfl_nreconfigure),
    .pfl_nreset       (pfl_nreset),
    .active_page      (active_page),
    .retry_cnt        (retry_cnt),
    .busy             (busy),
    .cfg_ok           (cfg_ok),
    .cfg_err          (cfg_err),
    .state_o          (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (state_o !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state_o), 32'(s));
  endtask

  task automatic pulse_req(input logic [2:0] p);
    cfg_req  = 1'b1;
    cfg_page = p;
    @(negedge clk);
    cfg_req  = 1'b0;
  endtask

  task automatic pulse_next();
    cfg_next = 1'b1;
    @(negedge clk);
    cfg_next = 1'b0;
  endtask

  // Drive a fresh conf_done low-then-high so the sequence completes.
  task automatic finish_ok(input string tag);
    wait_state(4'd6, 20, {tag, "_wait_done"});
    fpga_conf_done = 1'b0;
    step(3);
    fpga_conf_done = 1'b1;
    wait_state(4'd0, 20, {tag, "_idle"});
  endtask

  initial begin
    int n;
    logic [2:0] exp_pg [4];
    logic [1:0] exp_rt [4];
    exp_pg = '{3'd1, 3'd1, 3'd0, 3'd0};
    exp_rt = '{2'd0, 2'd1, 2'd0, 2'd1};

    sys_reset = 1'b1;
    fpga_conf_done = 1'b0;
    fl_done = 1'b0;
    fl_page = 3'd0;
    cfg_req = 1'b0;
    cfg_page = 3'd0;
    cfg_next = 1'b0;

    step(2);
    chk("rst_state", 32'(state_o), 32'd1);
    chk("rst_grant", 32'(pfl_grant), 32'd1);
    chk("rst_fl_req", 32'(fl_req), 32'd0);
    chk("rst_pgm", 32'(fpga_pgm), 32'd0);
    chk("rst_nreconf", 32'(pfl_nreconfigure), 32'd1);
    chk("rst_nreset", 32'(pfl_nreset), 32'd1);
    chk("rst_active", 32'(active_page), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ok_err", 32'({cfg_ok, cfg_err}), 32'd0);
    sys_reset = 1'b0;

    // 1. Boot
    step(5);
    fpga_conf_done = 1'b1;
    wait_state(4'd2, 10, "boot_read_sel");
    chk("boot_grant", 32'(pfl_grant), 32'd0);
    chk("boot_fl_req", 32'(fl_req), 32'd1);
    fl_done = 1'b1;
    fl_page = 3'd2;
    step(1);
    fl_done = 1'b0;
    chk("boot_apply", 32'(state_o), 32'd3);
    chk("boot_apply_grant", 32'({pfl_grant, fl_req}), 32'b10);
    step(1);
    chk("boot_nreconf_state", 32'(state_o), 32'd4);
    chk("boot_pgm", 32'(fpga_pgm), 32'd2);
    n = 0;
    while (pfl_nreconfigure === 1'b0 && n < 20) begin n++; step(1); end
    chk("boot_nreconf_len", 32'(n), 32'd4);
    n = 0;
    while (pfl_nreset === 1'b0 && n < 20) begin n++; step(1); end
    chk("boot_nreset_len", 32'(n), 32'd4);
    chk("boot_wait_done", 32'(state_o), 32'd6);
    fpga_conf_done = 1'b0;
    step(4);
    chk("boot_no_early_ok", 32'({state_o, cfg_ok}), 32'({4'd6, 1'b0}));
    fpga_conf_done = 1'b1;
    wait_state(4'd0, 10, "boot_idle");
    chk("boot_cfg_ok", 32'({cfg_ok, cfg_err}), 32'b10);
    chk("boot_active", 32'(active_page), 32'd2);
    chk("boot_busy", 32'(busy), 32'd0);

    // 2. Stale conf_done held high through WAIT_DONE
    pulse_req(3'd1);
    chk("stale_apply", 32'(state_o), 32'd3);
    wait_state(4'd6, 20, "stale_wait_done");
    n = 0;
    while (state_o === 4'd6 && n < 100) begin n++; step(1); end
    chk("stale_timeout_len", 32'(n), 32'd64);
    chk("stale_retry_apply", 32'(state_o), 32'd3);
    chk("stale_retry_cnt", 32'(retry_cnt), 32'd1);
    chk("stale_no_ok", 32'(cfg_ok), 32'd0);

    // 3. Second attempt on page 1, then factory fallback completes
    wait_state(4'd4, 5, "retry_nreconf");
    chk("retry_pgm", 32'(fpga_pgm), 32'd1);
    wait_state(4'd6, 20, "retry_wait_done");
    wait_state(4'd3, 80, "fallback_apply");
    chk("fallback_retry_cnt", 32'(retry_cnt), 32'd0);
    wait_state(4'd4, 5, "fallback_nreconf");
    chk("fallback_pgm", 32'(fpga_pgm), 32'd0);
    finish_ok("fallback");
    chk("fallback_ok", 32'({cfg_ok, cfg_err}), 32'b10);
    chk("fallback_active", 32'(active_page), 32'd0);

    // 4. Total failure
    pulse_req(3'd1);
    for (int i = 0; i < 4; i++) begin
      wait_state(4'd4, 100, "fail_nreconf");
      chk("fail_pgm", 32'(fpga_pgm), 32'(exp_pg[i]));
      chk("fail_retry", 32'(retry_cnt), 32'(exp_rt[i]));
      wait_state(4'd6, 20, "fail_wait_done");
    end
    wait_state(4'd0, 100, "fail_idle");
    chk("fail_err", 32'({cfg_ok, cfg_err}), 32'b01);
    chk("fail_busy", 32'(busy), 32'd0);
    chk("fail_active", 32'(active_page), 32'd0);

    // 5. Requests in IDLE
    pulse_req(3'd2);
    finish_ok("req2");
    chk("req2_active", 32'(active_page), 32'd2);
    cfg_next = 1'b1;
    pulse_req(3'd1);
    cfg_next = 1'b0;
    wait_state(4'd4, 5, "both_nreconf");
    chk("both_req_wins", 32'(fpga_pgm), 32'd1);
    finish_ok("both");
    chk("both_active", 32'(active_page), 32'd1);
    pulse_next();
    wait_state(4'd4, 5, "next_nreconf");
    chk("next_1_to_2", 32'(fpga_pgm), 32'd2);
    finish_ok("next");
    pulse_next();
    wait_state(4'd4, 5, "wrap_nreconf");
    chk("next_wrap", 32'(fpga_pgm), 32'd0);
    finish_ok("wrap");
    chk("wrap_active", 32'(active_page), 32'd0);
    pulse_req(3'd2);
    wait_state(4'd4, 5, "busy_nreconf");
    pulse_req(3'd1);
    chk("busy_ignored_state", 32'(state_o), 32'd4);
    finish_ok("busy");
    chk("busy_ignored_active", 32'(active_page), 32'd2);
    pulse_req(3'd5);
    wait_state(4'd4, 5, "clamp_nreconf");
    chk("clamp_pgm", 32'(fpga_pgm), 32'd0);
    finish_ok("clamp");
    chk("clamp_active", 32'(active_page), 32'd0);

    // 6. Asynchronous reset in the middle of NRECONF
    pulse_req(3'd1);
    wait_state(4'd4, 5, "arst_nreconf");
    step(1);
    chk("arst_pre_nreconf", 32'(pfl_nreconfigure), 32'd0);
    #2;
    sys_reset = 1'b1;
    #1;
    chk("arst_nreconf", 32'(pfl_nreconfigure), 32'd1);
    chk("arst_grant", 32'(pfl_grant), 32'd1);
    chk("arst_pgm", 32'(fpga_pgm), 32'd0);
    chk("arst_state", 32'(state_o), 32'd1);
    chk("arst_busy", 32'(busy), 32'd1);
    step(2);
    sys_reset = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pfl_cfg_sequencer.md
Name: pfl_cfg_sequencer

Overview:
Parametrised configuration sequencer between the system CPLD, the PFL core and the custom flash controller.
- Arbitrates flash ownership: PFL or the flash controller that reads the boot-page selector.
- Drives PFL page select, nreconfigure and nreset with timed pulses.
- Supervises FPGA conf_done with a timeout, retries the same page a bounded number of times, then falls back to the factory page.
- Adds N-page support, external page requests and round-robin "next page" stepping.

Parameters:
NUM_PAGES, 3, number of valid PFL pages (2..8)
PAGE_W, 3, width of fpga_pgm
FACTORY_PAGE, 0, fallback page index
NRECONF_CYC, 16, pfl_nreconfigure low time in clocks (>=1)
NRESET_CYC, 16, pfl_nreset low time in clocks (>=1)
CFG_TIMEOUT_CYC, 2**24, clocks allowed for conf_done, and for fl_done
MAX_RETRY, 1, retries of the same page before fallback
TMR_W, 25, timer width; must hold max(NRECONF_CYC, NRESET_CYC, CFG_TIMEOUT_CYC)

Ports:
clkin_max_100  in  1  system clock
sys_reset  in  1  asynchronous active-high reset
fpga_conf_done  in  1  asynchronous; synchronised internally
fl_done  in  1  flash controller read complete (level, sync)
fl_page  in  PAGE_W  boot page read by flash controller; valid when fl_done=1
cfg_req  in  1  one-cycle request to configure cfg_page
cfg_page  in  PAGE_W  requested page
cfg_next  in  1  one-cycle request to configure (active_page+1) mod NUM_PAGES
pfl_grant  out  1  1 = PFL owns flash, 0 = flash controller owns flash
fl_req  out  1  1 = flash controller runs a selector read
fpga_pgm  out  PAGE_W  PFL page select
pfl_nreconfigure  out  1  active-low reconfigure pulse
pfl_nreset  out  1  active-low PFL reset pulse
active_page  out  PAGE_W  last successfully configured page
retry_cnt  out  2  retries used on the current target
busy  out  1  sequence in progress
cfg_ok  out  1  last sequence succeeded
cfg_err  out  1  last sequence failed, including factory
state_o  out  4  state encoding, for LEDs

Behaviour:
Reset values (asynchronous):
- state=BOOT_WAIT, pfl_grant=1, fl_req=0, fpga_pgm=FACTORY_PAGE.
- pfl_nreconfigure=1, pfl_nreset=1, active_page=FACTORY_PAGE.
- retry_cnt=0, busy=1, cfg_ok=0, cfg_err=0, timer=0.
- Two synchroniser flops are also cleared.

Synchroniser:
- conf_done_s = fpga_conf_done delayed by 2 flops.
- All decisions use conf_done_s.

Timer:
- Single up-counter, cleared on every state entry.
- "Expires" when it equals the limit minus 1, so the state lasts exactly the limit in clocks.

States:
- BOOT_WAIT: waits for the power-up factory configuration.
  - conf_done_s=1 -> READ_SEL.
  - Timeout -> cfg_err=1 -> IDLE.
- READ_SEL: pfl_grant=0, fl_req=1.
  - fl_done=1 -> target=fl_page, or FACTORY_PAGE if fl_page>=NUM_PAGES -> APPLY.
  - Timeout -> target=FACTORY_PAGE -> APPLY.
- APPLY: pfl_grant=1, fl_req=0, fpga_pgm<=target, armed=0. Lasts 1 clock -> NRECONF.
- NRECONF: pfl_nreconfigure=0 for NRECONF_CYC clocks -> NRESET.
- NRESET: pfl_nreset=0 for NRESET_CYC clocks -> WAIT_DONE.
- WAIT_DONE: conf_done_s=0 sets armed=1; conf_done_s=1 is ignored while armed=0, because of the stale high from the previous image.
  - armed and conf_done_s=1 -> cfg_ok=1, cfg_err=0, active_page=target, retry_cnt=0 -> IDLE.
  - Timeout with retry_cnt<MAX_RETRY -> retry_cnt+1 -> APPLY, same target.
  - Timeout at the limit and target!=FACTORY_PAGE -> target=FACTORY_PAGE, retry_cnt=0 -> APPLY.
  - Timeout at the limit and target=FACTORY_PAGE -> cfg_err=1, cfg_ok=0 -> IDLE.
- IDLE: busy=0; all other states have busy=1.
  - cfg_req -> target=cfg_page, clamped to FACTORY_PAGE if cfg_page>=NUM_PAGES.
  - cfg_next -> target=active_page+1, wrapping to 0 at NUM_PAGES.
  - Both requests clear retry_cnt and cfg_ok/cfg_err, then go to APPLY.
  - If cfg_req and cfg_next arrive together, cfg_req wins.

Request and reset rules:
- cfg_req and cfg_next are ignored outside IDLE and are not queued.
- sys_reset mid-sequence returns all outputs to their reset values at once. The PFL then sees nreconfigure and nreset high and the flash returns to PFL.

Decomposition:
- Shared package pfl_cfg_pkg holds:
  - the state encoding constants, state_o values fixed for LED use: BOOT_WAIT=1, READ_SEL=2, APPLY=3, NRECONF=4, NRESET=5, WAIT_DONE=6, IDLE=0;
  - the PAGE_W default;
  - the retry counter width.
- Sub-module: sync_2ff, a 1-bit two-flop synchroniser with async active-high clear. It is reused for conf_done.

Test Plan:
Bench parameters: NUM_PAGES=3, FACTORY_PAGE=0, NRECONF_CYC=4, NRESET_CYC=4, CFG_TIMEOUT_CYC=64, MAX_RETRY=1.

1. Boot: conf_done high at cycle 5, fl_done with fl_page=2.
   - Required: READ_SEL with pfl_grant=0, fl_req=1.
   - Then fpga_pgm=2, nreconfigure low 4 clocks, nreset low 4 clocks.
   - conf_done low then high -> cfg_ok=1, active_page=2, busy=0.
2. Stale conf_done: hold conf_done=1 through the whole of WAIT_DONE.
   - Required: no success; timeout after 64 clocks, then retry_cnt=1.
3. Retry and fallback: page 1 never completes.
   - Required: two attempts on page 1, then fpga_pgm=0, retry_cnt=0.
   - Factory completes -> cfg_ok=1, active_page=0.
4. Total failure: nothing completes.
   - Required: page 1 x2, factory x2, then cfg_err=1, busy=0, state_o=0.
5. Requests in IDLE with active_page=2: cfg_next and cfg_req(cfg_page=1) in the same cycle.
   - Required: target=1, because cfg_req wins.
   - Separately, a cfg_next alone wraps to page 0; cfg_page=5 is clamped to 0; a cfg_req while busy is ignored.
6. Reset mid-NRECONF: assert sys_reset.
   - Required: pfl_nreconfigure=1, pfl_grant=1, fpga_pgm=0, state_o=1 in the same cycle, with no clock edge needed.
